s_mem_arbiter: RTL

- Round-robin arbiter and access sequencer for the single-port 256x8 S memory (s_memory).
- Shares the one address/data/wren/q port between up to N requesters, e.g. the fill engine, the KSA shuffle engine and the PRGA/decrypt engine.
- Grants burst ownership per requester and tags read data back to whichever requester issued the read.

---
 rtl/s_mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin owner arbitration and access sequencing for the
// single-port 256x8 S memory. One requester owns the port for a whole burst;
// read results are tagged back to the requester that issued them, even after
// ownership has moved on.
//
// Handshake: req[k] is a level held for the whole burst. gnt[k] is registered
// and one-hot; the owner's rd/wr/addr/wdata reach the memory only while both
// gnt[k] and req[k] are high. Dropping req[k] releases ownership on the next
// edge, and any access strobed in that release cycle is ignored. Strobes from
// a requester without gnt are dropped and set the sticky viol flag.
module s_mem_arbiter #(
  parameter int N       = 3,
  parameter int MEM_LAT = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     rd,
  input  logic [N-1:0]     wr,
  input  logic [8*N-1:0]   addr,
  input  logic [8*N-1:0]   wdata,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     rvalid,
  output logic [7:0]       rdata,
  output logic [7:0]       mem_address,
  output logic [7:0]       mem_data,
  output logic             mem_wren,
  input  logic [7:0]       mem_q,
  output logic             busy,
  output logic             viol,
  output logic             dbg_state
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [IW-1:0]       own_q, own_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [7:0]          last_addr_q, last_data_q;
  logic                viol_q;
  logic [MEM_LAT-1:0]  tag_v_q;
  logic [MEM_LAT-1:0][IW-1:0] tag_id_q;

  logic [N-1:0]        cand;
  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic                grant_new;
  logic [7:0]          own_addr, own_wdata;
  logic                own_req, own_rd, own_wr;
  logic                rd_accept;
  logic                viol_set;

  // Round-robin search: first requester at or after the pointer, wrapping,
  // excluding the current owner (which only matters when it is releasing).
  always_comb begin
    int j;
    cand      = req & ~gnt_q;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // Next-state logic: grant from IDLE, hold while the owner keeps req,
  // hand over in the release edge with no dead cycle when someone waits.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) grant_new = 1'b1;
      end
      ST_OWN: begin
        if (!req[own_q]) begin
          if (win_found) begin
            grant_new = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    if (grant_new) begin
      state_d = ST_OWN;
      gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
      own_d   = win_idx;
      ptr_d   = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  // Owner's request slice, selected by the registered owner index.
  always_comb begin
    int own_i;
    own_i     = int'(own_q);
    own_addr  = addr[own_i*8 +: 8];
    own_wdata = wdata[own_i*8 +: 8];
    own_req   = req[own_q];
    own_rd    = rd[own_q];
    own_wr    = wr[own_q];
  end

  assign busy        = |gnt_q;
  assign gnt         = gnt_q;
  assign viol        = viol_q;
  assign dbg_state   = (state_q == ST_OWN);
  assign mem_address = busy ? own_addr  : last_addr_q;
  assign mem_data    = busy ? own_wdata : last_data_q;
  assign mem_wren    = busy & own_req & own_wr & ~reset;
  assign rd_accept   = busy & own_req & own_rd & ~own_wr;
  assign viol_set    = |((rd | wr) & ~gnt_q);
  assign rdata       = mem_q;

  // Read tag at the end of the latency pipe names the requester whose data
  // is on mem_q this cycle.
  always_comb begin
    rvalid = '0;
    if (tag_v_q[MEM_LAT-1]) rvalid[tag_id_q[MEM_LAT-1]] = 1'b1;
  end

  // State, grant, pointer, held mux values, sticky violation and read tags.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      own_q       <= '0;
      ptr_q       <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      viol_q      <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      own_q       <= own_d;
      ptr_q       <= ptr_d;
      last_addr_q <= mem_address;
      last_data_q <= mem_data;
      if (viol_set) viol_q <= 1'b1;
      tag_v_q[0]  <= rd_accept;
      tag_id_q[0] <= own_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

endmodule
